// File: rtl/pong_pkg.sv
// pong_pkg: shared definitions for the ping-pong design.
//   game_state_e : 2-bit game state encoding (IDLE/SERVE/PLAY/OVER)
//   CENTER_X/Y   : ball serve position
//   UP_Y/DOWN_Y  : top and bottom field walls
//   LEFT_X/RIGHT_X : paddle columns, which double as goal lines
package pong_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_PLAY  = 2'd2,
        ST_OVER  = 2'd3
    } game_state_e;

    localparam int unsigned CENTER_X = 320;
    localparam int unsigned CENTER_Y = 240;
    localparam int unsigned UP_Y     = 140;
    localparam int unsigned DOWN_Y   = 340;
    localparam int unsigned LEFT_X   = 150;
    localparam int unsigned RIGHT_X  = 490;

endpackage

// File: rtl/pong_game_ctrl_btn_edge.sv
// btn_edge: registered rising-edge detector for an already-debounced level.
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset (clears the history register)
//   btn_i   : button level
//   rise_o  : high for the cycle in which btn_i is high and was low last cycle
module btn_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic rise_o
);

    logic btn_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) btn_q <= 1'b0;
        else         btn_q <= btn_i;
    end

    assign rise_o = btn_i & ~btn_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: game sequencer for the ping-pong design.
//   clk, reset (async, active-low)
//   frame_tick   : one-cycle pulse per video frame
//   start        : debounced start button level
//   pause        : debounced pause button level (only with PONG_PAUSE_EN)
//   ball_x       : current ball x position
//   game_state   : 0=IDLE 1=SERVE 2=PLAY 3=OVER
//   ball_load    : pulse, ball recentres with serve velocity
//   ball_step_en : pulse, ball advances one step (combinational from frame_tick)
//   serve_dir    : 0=toward p1 (left), 1=toward p2 (right)
//   p1_score, p2_score, winner (0=none 1=p1 2=p2)
// Optional feature: define PONG_PAUSE_EN to add the pause input and pause flag.
module pong_game_ctrl #(
    parameter int unsigned LEFT_X       = 150,
    parameter int unsigned RIGHT_X      = 490,
    parameter int unsigned WIN_SCORE    = 7,
    parameter int unsigned SERVE_FRAMES = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start,
`ifdef PONG_PAUSE_EN
    input  logic       pause,
`endif
    input  logic [9:0] ball_x,
    output logic [1:0] game_state,
    output logic       ball_load,
    output logic       ball_step_en,
    output logic       serve_dir,
    output logic [3:0] p1_score,
    output logic [3:0] p2_score,
    output logic [1:0] winner
);
    import pong_pkg::*;

    localparam logic [9:0] LEFT_C     = 10'(LEFT_X);
    localparam logic [9:0] RIGHT_C    = 10'(RIGHT_X);
    localparam logic [3:0] WIN_C      = 4'(WIN_SCORE);
    localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);

    game_state_e state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  p1_q, p1_d, p2_q, p2_d;
    logic [1:0]  winner_q, winner_d;
    logic        serve_dir_q, serve_dir_d;
    logic        ball_load_q, ball_load_d;
    logic        step_en;
    logic        play_active;
    logic        start_rise;

    btn_edge u_start_edge (
        .clk_i  (clk),
        .rst_ni (reset),
        .btn_i  (start),
        .rise_o (start_rise)
    );

`ifdef PONG_PAUSE_EN
    logic pause_rise;
    logic paused_q, paused_d;

    btn_edge u_pause_edge (
        .clk_i  (clk),
        .rst_ni (reset),
        .btn_i  (pause),
        .rise_o (pause_rise)
    );
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        p1_d        = p1_q;
        p2_d        = p2_q;
        winner_d    = winner_q;
        serve_dir_d = serve_dir_q;
        step_en     = 1'b0;
`ifdef PONG_PAUSE_EN
        paused_d    = paused_q;
        play_active = ~paused_q;
`else
        play_active = 1'b1;
`endif

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start_rise) begin
                    state_d     = ST_SERVE;
                    p1_d        = '0;
                    p2_d        = '0;
                    winner_d    = '0;
                    serve_dir_d = 1'b1;
                end
            end
            ST_SERVE: begin
                if (frame_tick) begin
                    if (cnt_q == SERVE_LAST) state_d = ST_PLAY;
                    else                     cnt_d   = cnt_q + 8'd1;
                end
            end
            ST_PLAY: begin
`ifdef PONG_PAUSE_EN
                if (pause_rise) paused_d = ~paused_q;
`endif
                if (frame_tick && play_active) begin
                    // Step still fires on a miss cycle; the next-cycle load overrides it.
                    step_en = 1'b1;
                    if (ball_x <= LEFT_C) begin
                        p2_d        = p2_q + 4'd1;
                        serve_dir_d = 1'b0;
                        if (p2_d == WIN_C) begin
                            state_d  = ST_OVER;
                            winner_d = 2'd2;
                        end else begin
                            state_d  = ST_SERVE;
                        end
                    end else if (ball_x >= RIGHT_C) begin
                        p1_d        = p1_q + 4'd1;
                        serve_dir_d = 1'b1;
                        if (p1_d == WIN_C) begin
                            state_d  = ST_OVER;
                            winner_d = 2'd1;
                        end else begin
                            state_d  = ST_SERVE;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Every SERVE entry restarts the frame counter and recentres the ball.
        ball_load_d = 1'b0;
        if (state_d == ST_SERVE && state_q != ST_SERVE) begin
            cnt_d       = '0;
            ball_load_d = 1'b1;
        end

`ifdef PONG_PAUSE_EN
        if (state_d != ST_PLAY) paused_d = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            p1_q        <= '0;
            p2_q        <= '0;
            winner_q    <= '0;
            serve_dir_q <= 1'b0;
            ball_load_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            p1_q        <= p1_d;
            p2_q        <= p2_d;
            winner_q    <= winner_d;
            serve_dir_q <= serve_dir_d;
            ball_load_q <= ball_load_d;
        end
    end

`ifdef PONG_PAUSE_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) paused_q <= 1'b0;
        else        paused_q <= paused_d;
    end
`endif

    assign game_state   = state_q;
    assign ball_load    = ball_load_q;
    assign ball_step_en = step_en;
    assign serve_dir    = serve_dir_q;
    assign p1_score     = p1_q;
    assign p2_score     = p2_q;
    assign winner       = winner_q;

endmodule
